// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM states, RAM direction encodings and
// default bus widths used by the instruction RAM, fetch and memory-control blocks.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: assembles big-endian instruction words from a byte stream.
// Optional macro INSTR_LOADER_CHECKSUM_EN adds a running XOR of data bytes.
// Ports:
//   Clk, Reset   clock, async active-high reset
//   clear        restart packing (byte index and checksum) for a new load
//   take         a byte transfers on this edge
//   byte_in      stream byte
//   word_next    word as it will be after the current byte is shifted in
//   word_full    current transfer completes a word
//   xor_sum      running XOR of all data bytes (checksum build only)
module byte_packer
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_next,
`ifdef INSTR_LOADER_CHECKSUM_EN
  output logic [7:0]        xor_sum,
`endif
  output logic              word_full
);

  logic [DATA_W-1:0] word;
  logic [1:0]        byte_idx;

  assign word_next = {word[DATA_W-9:0], byte_in};
  assign word_full = take && (byte_idx == 2'd3);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (take) begin
      word     <= word_next;
      byte_idx <= byte_idx + 2'd1;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      xor_sum <= '0;
    end else if (clear) begin
      xor_sum <= '0;
    end else if (take) begin
      xor_sum <= xor_sum ^ byte_in;
    end
  end
`endif

endmodule

// File: rtl/instr_loader.sv
// instr_loader: writer side of the instruction RAM. Packs a host byte stream
// into big-endian words and writes them to consecutive RAM addresses while
// holding the CPU fetch path off via cpu_hold.
// Optional macro INSTR_LOADER_CHECKSUM_EN: a trailing checksum byte (XOR of
// all data bytes) is consumed after the last word and compared; error flags
// a mismatch.
// Ports:
//   Clk, Reset                 clock, async active-high reset
//   start, base_addr, word_count   load request (sampled in IDLE)
//   byte_in, byte_valid, byte_ready  byte stream handshake
//   Enable, RW, Address, DataIn    instruction RAM write port
//   busy, done, cpu_hold, words_written, error   status
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              Enable,
  output logic              RW,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataIn,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [CNT_W-1:0]  words_written,
  output logic              error
);

  loader_state_t     state, state_next;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  ww_next;
  logic [ADDR_W-1:0] addr_ptr;
  logic [DATA_W-1:0] word_next;
  logic              word_full;
  logic              start_acc;
  logic              take;

  assign start_acc = (state == ST_IDLE) && start;
  assign take      = (state == ST_COLLECT) && byte_valid;
  assign ww_next   = words_written + CNT_W'(1);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] xor_sum;
`endif

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (start_acc),
    .take      (take),
    .byte_in   (byte_in),
    .word_next (word_next),
`ifdef INSTR_LOADER_CHECKSUM_EN
    .xor_sum   (xor_sum),
`endif
    .word_full (word_full)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    Enable     = 1'b0;
    RW         = RAM_READ;
    busy       = 1'b1;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        cpu_hold = 1'b0;
        if (start) begin
          state_next = (word_count != '0) ? ST_COLLECT : ST_DONE;
        end
      end
      ST_COLLECT: begin
        byte_ready = 1'b1;
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        Enable = 1'b1;
        RW     = RAM_WRITE;
        if (ww_next == count_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_next = ST_CHECK;
`else
          state_next = ST_DONE;
`endif
        end else begin
          state_next = ST_COLLECT;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address/DataIn are captured on the edge that accepts the 4th byte so the
  // write cycle presents them immediately; they then hold until the next word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q       <= '0;
      addr_ptr      <= '0;
      words_written <= '0;
      Address       <= '0;
      DataIn        <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      error         <= 1'b0;
`endif
    end else begin
      if (start_acc) begin
        count_q       <= word_count;
        addr_ptr      <= base_addr;
        words_written <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        error         <= 1'b0;
`endif
      end
      if (state == ST_COLLECT && word_full) begin
        Address <= addr_ptr;
        DataIn  <= word_next;
      end
      if (state == ST_WRITE) begin
        addr_ptr      <= addr_ptr + ADDR_W'(1);
        words_written <= ww_next;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (state == ST_CHECK && byte_valid) begin
        error <= (byte_in != xor_sum);
      end
`endif
    end
  end

`ifndef INSTR_LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, Enable, RW, busy, done, cpu_hold, error;
  logic [15:0] Address;
  logic [31:0] DataIn;
  logic [15:0] words_written;

  instr_loader #(
    .ADDR_W (16),
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .Enable        (Enable),
    .RW            (RW),
    .Address       (Address),
    .DataIn        (DataIn),
    .busy          (busy),
    .done          (done),
    .cpu_hold      (cpu_hold),
    .words_written (words_written),
    .error         (error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int   ww;      // -1: words_written not checked
    logic err;
  } dn_t;

  wr_t        exp_wr[$];
  dn_t        exp_dn[$];
  logic [7:0] stim[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every RAM write and every done pulse against the scoreboard.
  initial begin : monitor
    bit   after_done;
    wr_t  w;
    dn_t  d;
    after_done = 0;
    forever begin
      @(negedge Clk);
      if (after_done) begin
        chk("done_one_cycle", {61'd0, done, busy, cpu_hold}, 64'd0);
        after_done = 0;
      end
      if (Enable === 1'b1 && RW === 1'b0) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {16'd0, Address, DataIn}, 64'd0);
          miscompares += (Address == 0 && DataIn == 0) ? 1 : 0;
        end else begin
          w = exp_wr.pop_front();
          chk("write_addr", 64'(Address), 64'(w.addr));
          chk("write_data", 64'(DataIn), 64'(w.data));
          chk("ready_in_write", 64'(byte_ready), 64'd0);
        end
      end
      if (done === 1'b1) begin
        if (exp_dn.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
        end else begin
          d = exp_dn.pop_front();
          if (d.ww >= 0) chk("words_written", 64'(words_written), 64'(d.ww));
          chk("error", 64'(error), 64'(d.err));
          chk("hold_in_done", {62'd0, busy, cpu_hold}, 64'd3);
        end
        after_done = 1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, {57'd0, byte_ready, Enable, RW, busy, done, cpu_hold, error}, 64'b0010000);
    chk({tag, "_addr"}, 64'(Address), 64'd0);
    chk({tag, "_data"}, 64'(DataIn), 64'd0);
    chk({tag, "_ww"}, 64'(words_written), 64'd0);
  endtask

  task automatic issue_start(input logic [15:0] base, input logic [15:0] cnt);
    @(negedge Clk);
    start = 1'b1;
    base_addr = base;
    word_count = cnt;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Reference model: word i of the load lands at base+i (mod 2^16) holding
  // stream bytes 4i..4i+3, first byte most significant. With the checksum
  // build one extra byte follows; error = it differs from XOR of the data.
  // mode: 0 valid held, 1 valid toggles, 2 random gaps, 3 held + stray start.
  task automatic run_load(input logic [15:0] base, input logic [15:0] cnt,
                          input int mode, input bit bad_ck);
    logic [7:0] x;
    logic [7:0] ck;
    logic       exp_err;
    logic       v;
    bit         xfer;
    int         idx, cyc;
    x = 8'h00;
    exp_err = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_wr.push_back('{addr: base + 16'(i),
                         data: {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]}});
      for (int j = 0; j < 4; j++) x = x ^ stim[4*i+j];
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (cnt != 0) begin
      ck = bad_ck ? (x ^ 8'h5A) : x;
      exp_err = (ck != x);
      stim.push_back(ck);
    end
`else
    ck = x;
    exp_err = bad_ck & 1'b0;
`endif
    exp_dn.push_back('{ww: (cnt == 0) ? -1 : int'(cnt), err: exp_err});
    issue_start(base, cnt);
    idx = 0;
    cyc = 0;
    while (idx < stim.size() && cyc < 400) begin
      @(negedge Clk);
      case (mode)
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      if (mode == 3 && cyc == 3) begin
        start = 1'b1;
        base_addr = ~base;
        word_count = 16'd7;
      end else begin
        start = 1'b0;
      end
      byte_valid = v;
      byte_in = v ? stim[idx] : 8'($urandom);
      xfer = v && byte_ready;
      @(posedge Clk);
      if (xfer) idx++;
      cyc++;
    end
    @(negedge Clk);
    byte_valid = 1'b0;
    start = 1'b0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 400) begin
      @(negedge Clk);
      cyc++;
    end
    if (idx < stim.size() || cyc >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: got %0d bytes taken expected %0d", idx, stim.size());
    end
    stim.delete();
    repeat (2) @(negedge Clk);
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0] vec[8];
    vec = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    repeat (3) @(negedge Clk);
    check_reset_vals("reset_held");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check_reset_vals("reset_released");

    // Directed: valid held, then toggled.
    for (int m = 0; m < 2; m++) begin
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(vec[i]);
      run_load(16'h0000, 16'd2, m, 1'b0);
      chk("hold_after_done", {62'd0, cpu_hold, busy}, 64'd0);
      chk("ww_holds", 64'(words_written), 64'd2);
    end

    // Address wrap.
    fill_random(8);
    run_load(16'hFFFF, 16'd2, 0, 1'b0);

    // Zero-length load: done with no RAM access.
    stim.delete();
    run_load(16'h1234, 16'd0, 0, 1'b0);

    // Start while busy is ignored.
    fill_random(12);
    run_load(16'h0100, 16'd3, 3, 1'b0);

    // Reset after 2 bytes of word 1 of a 3-word load.
    issue_start(16'h0200, 16'd3);
    for (int i = 0; i < 2; i++) begin
      byte_valid = 1'b1;
      byte_in = 8'(8'hA0 + i);
      @(negedge Clk);
    end
    byte_valid = 1'b0;
    Reset = 1'b1;
    #1;
    check_reset_vals("reset_mid_load");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_vals("after_mid_reset");
    fill_random(12);
    run_load(16'h0200, 16'd3, 0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(16'h0040, 16'd1, 0, 1'b0);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(16'h0040, 16'd1, 0, 1'b1);
    chk("error_holds", 64'(error), 64'd1);
`endif

    // Randomized loads.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 4);
      fill_random(4 * n);
      run_load(16'($urandom), 16'(n), $urandom_range(0, 2), 1'($urandom));
    end

    repeat (3) @(negedge Clk);
    chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    chk("dones_drained", 64'(exp_dn.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
